// File: rtl/ibex_pext_mult_iter.sv
// Iterative packed multiplier for P-ext: one 17x17 signed partial product per cycle,
// accumulated into a 64-bit result returned over a valid/ready handshake.
module ibex_pext_mult_iter #(
    parameter bit BypassReady = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [1:0]  mode_i,
    input  logic        signed_a_i,
    input  logic        signed_b_i,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    input  logic        kill_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [63:0] result_o
);

    localparam logic [1:0] ModeM8x8   = 2'd0;
    localparam logic [1:0] ModeM16x16 = 2'd1;
    localparam logic [1:0] ModeM32x16 = 2'd2;
    localparam logic [1:0] ModeM32x32 = 2'd3;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e      r_state;
    state_e      w_state_d;
    logic [1:0]  r_step;
    logic [1:0]  r_mode;
    logic        r_sa;
    logic        r_sb;
    logic [31:0] r_op_a;
    logic [31:0] r_op_b;
    logic [63:0] r_acc;

    logic        w_accept;
    logic        w_last;
    logic [16:0] w_mul_a;
    logic [16:0] w_mul_b;
    logic [5:0]  w_shift;
    logic [33:0] w_prod;
    logic [63:0] w_addend_base;
    logic [63:0] w_addend;
    logic [7:0]  w_byte_a;
    logic [7:0]  w_byte_b;
    logic [15:0] w_half_a;
    logic [15:0] w_half_b;
    logic [16:0] w_a_lo;
    logic [16:0] w_a_hi;
    logic [16:0] w_b_lo;
    logic [16:0] w_b_hi;

    assign ready_o  = (r_state == StIdle) | (BypassReady & (r_state == StDone) & ready_i);
    assign w_accept = valid_i & ready_o & ~kill_i;
    assign valid_o  = (r_state == StDone);
    assign result_o = r_acc;

    assign w_last = ((r_mode == ModeM16x16) || (r_mode == ModeM32x16)) ? (r_step == 2'd1)
                                                                       : (r_step == 2'd3);

    // Low halves of 32-bit operands are magnitude bits only; the high half carries the sign.
    assign w_a_lo   = {1'b0, r_op_a[15:0]};
    assign w_a_hi   = {r_op_a[31] & r_sa, r_op_a[31:16]};
    assign w_b_lo   = {1'b0, r_op_b[15:0]};
    assign w_b_hi   = {r_op_b[31] & r_sb, r_op_b[31:16]};
    assign w_byte_a = r_op_a[{r_step, 3'b000} +: 8];
    assign w_byte_b = r_op_b[{r_step, 3'b000} +: 8];
    assign w_half_a = r_op_a[{r_step[0], 4'b0000} +: 16];
    assign w_half_b = r_op_b[{r_step[0], 4'b0000} +: 16];

    always_comb begin
        w_mul_a = '0;
        w_mul_b = '0;
        w_shift = '0;
        unique case (r_mode)
            ModeM8x8: begin
                w_mul_a = {{9{w_byte_a[7] & r_sa}}, w_byte_a};
                w_mul_b = {{9{w_byte_b[7] & r_sb}}, w_byte_b};
                w_shift = {r_step, 4'b0000};
            end
            ModeM16x16: begin
                w_mul_a = {w_half_a[15] & r_sa, w_half_a};
                w_mul_b = {w_half_b[15] & r_sb, w_half_b};
                w_shift = {r_step[0], 5'b00000};
            end
            ModeM32x16: begin
                w_mul_a = r_step[0] ? w_a_hi : w_a_lo;
                w_mul_b = {r_op_b[15] & r_sb, r_op_b[15:0]};
                w_shift = {1'b0, r_step[0], 4'b0000};
            end
            ModeM32x32: begin
                w_mul_a = r_step[0] ? w_a_hi : w_a_lo;
                w_mul_b = r_step[1] ? w_b_hi : w_b_lo;
                w_shift = {r_step[1] & r_step[0], r_step[1] ^ r_step[0], 4'b0000};
            end
        endcase
    end

    assign w_prod = $signed(w_mul_a) * $signed(w_mul_b);

    // Lane modes drop the product into a disjoint field; wide modes accumulate sign-extended.
    always_comb begin
        w_addend_base = '0;
        unique case (r_mode)
            ModeM8x8:   w_addend_base = {48'd0, w_prod[15:0]};
            ModeM16x16: w_addend_base = {32'd0, w_prod[31:0]};
            ModeM32x16,
            ModeM32x32: w_addend_base = {{30{w_prod[33]}}, w_prod};
        endcase
    end

    assign w_addend = w_addend_base << w_shift;

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle: if (w_accept) w_state_d = StBusy;
            StBusy: begin
                if (kill_i)      w_state_d = StIdle;
                else if (w_last) w_state_d = StDone;
            end
            StDone: begin
                if (kill_i)        w_state_d = StIdle;
                else if (ready_i)  w_state_d = w_accept ? StBusy : StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= StIdle;
            r_step  <= '0;
            r_mode  <= '0;
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_acc   <= '0;
        end else begin
            r_state <= w_state_d;
            if (w_accept) begin
                r_mode <= mode_i;
                r_sa   <= signed_a_i;
                r_sb   <= signed_b_i;
                r_op_a <= op_a_i;
                r_op_b <= op_b_i;
                r_acc  <= '0;
                r_step <= '0;
            end else if ((r_state == StBusy) && !kill_i) begin
                r_acc  <= r_acc + w_addend;
                r_step <= r_step + 2'd1;
            end
        end
    end

endmodule
